// File: rtl/controle_telas_pkg.sv
// Shared definitions for the screen sequencer: state encoding (the screen
// selector decodes the same values), VGA counter width and width helpers.
package controle_telas_pkg;

   typedef enum logic [1:0] {
      ST_INICIAL = 2'd0,
      ST_JOGO    = 2'd1,
      ST_VITORIA = 2'd2,
      ST_DERROTA = 2'd3
   } estado_t;

   localparam int VGA_W = 10;

   // Bits needed to hold every value from 0 up to valor, never less than one.
   function automatic int largura(input int valor);
      return (valor < 2) ? 1 : $clog2(valor + 1);
   endfunction

   function automatic int maior(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/controle_telas_if.sv
// Bundle between the sequencer and its surroundings: VGA counters and game
// events come in, the screen selection and game-restart strobe go out.
interface controle_telas_if;
   import controle_telas_pkg::*;

   logic [VGA_W-1:0] h_counter;
   logic [VGA_W-1:0] v_counter;
   logic             vitoria;
   logic             derrota;
   estado_t          estado;
   logic             troca;
   logic             jogo_reset;
   logic             frame_tick;

   modport master (
      input  h_counter, v_counter, vitoria, derrota,
      output estado, troca, jogo_reset, frame_tick
   );

   modport slave (
      output h_counter, v_counter, vitoria, derrota,
      input  estado, troca, jogo_reset, frame_tick
   );

endinterface

// File: rtl/controle_telas_debounce_botao.sv
// Start-button conditioning: two-flop synchronizer, a counter that only runs
// while the synced level stays high, and a single pulse per press.
module controle_telas_debounce_botao
   import controle_telas_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int            CW     = largura(DEBOUNCE_CYC);
   localparam logic [CW-1:0] ALVO   = CW'(DEBOUNCE_CYC);
   localparam logic [CW-1:0] PENULT = CW'(DEBOUNCE_CYC - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Bring the raw asynchronous button into the clock domain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Count consecutive high cycles, saturating so a held button cannot retrigger.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (!sync2) begin
         cnt <= '0;
      end else if (cnt != ALVO) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Pulse exactly on the cycle the counter arrives at the debounce length.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         press <= 1'b0;
      end else begin
         press <= sync2 && (cnt == PENULT);
      end
   end

endmodule

// File: rtl/controle_telas.sv
// Game screen sequencer: walks INICIAL -> JOGO -> VITORIA/DERROTA -> INICIAL,
// shows the state to the screen selector only at the start of vertical
// blanking, blinks the start screen and strobes a game restart.
module controle_telas
   import controle_telas_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 500000,
   parameter int BLINK_FRAMES = 30,
   parameter int HOLD_FRAMES  = 60,
   parameter int AUTO_FRAMES  = 600,
   parameter int V_TICK       = 480
) (
   input logic             clk,
   input logic             reset,
   input logic             btn_start,
   controle_telas_if.master tela
);

   localparam int               FMAX    = maior(HOLD_FRAMES, AUTO_FRAMES);
   localparam int               FW      = largura(FMAX);
   localparam int               BW      = largura(BLINK_FRAMES);
   localparam logic [FW-1:0]    F_MAX   = FW'(FMAX);
   localparam logic [BW-1:0]    B_ULT   = BW'(BLINK_FRAMES - 1);
   localparam logic [VGA_W-1:0] V_LINHA = VGA_W'(V_TICK);

   logic          start_press;
   logic          casa;
   logic          casa_d;
   logic          frame_tick_r;
   logic          hold_ok;
   logic          auto_ok;
   estado_t       st;
   estado_t       estado_r;
   logic [FW-1:0] fcnt;
   logic [BW-1:0] bcnt;
   logic          troca_r;
   logic          jogo_reset_r;

   controle_telas_debounce_botao #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) u_debounce_botao (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_start),
      .press (start_press)
   );

   assign casa = (tela.h_counter == '0) && (tela.v_counter == V_LINHA);

   // A zero hold time accepts presses immediately, so no comparison is built.
   if (HOLD_FRAMES == 0) begin : g_sem_hold
      assign hold_ok = 1'b1;
   end else begin : g_hold
      localparam logic [FW-1:0] F_HOLD = FW'(HOLD_FRAMES);
      assign hold_ok = (fcnt >= F_HOLD);
   end

   // Auto return exists only when a nonzero frame count is configured.
   if (AUTO_FRAMES == 0) begin : g_sem_auto
      assign auto_ok = 1'b0;
   end else begin : g_auto
      localparam logic [FW-1:0] F_AUTO = FW'(AUTO_FRAMES);
      assign auto_ok = (fcnt == F_AUTO);
   end

   // One tick per frame from the rising edge of the blanking match, even if the counters stall on it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         casa_d       <= 1'b0;
         frame_tick_r <= 1'b0;
      end else begin
         casa_d       <= casa;
         frame_tick_r <= casa & ~casa_d;
      end
   end

   // Sequencer with its frame counter, blink counter and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st           <= ST_INICIAL;
         estado_r     <= ST_INICIAL;
         troca_r      <= 1'b0;
         jogo_reset_r <= 1'b0;
         fcnt         <= '0;
         bcnt         <= '0;
      end else begin
         jogo_reset_r <= 1'b0;
         if (frame_tick_r) begin
            estado_r <= st;
         end
         case (st)
            ST_INICIAL: begin
               fcnt <= '0;
               if (start_press) begin
                  st           <= ST_JOGO;
                  jogo_reset_r <= 1'b1;
                  troca_r      <= 1'b0;
                  bcnt         <= '0;
               end else if (frame_tick_r) begin
                  if (bcnt == B_ULT) begin
                     bcnt    <= '0;
                     troca_r <= ~troca_r;
                  end else begin
                     bcnt <= bcnt + 1'b1;
                  end
               end
            end
            ST_JOGO: begin
               fcnt    <= '0;
               troca_r <= 1'b0;
               bcnt    <= '0;
               if (tela.derrota) begin
                  st <= ST_DERROTA;
               end else if (tela.vitoria) begin
                  st <= ST_VITORIA;
               end
            end
            default: begin
               troca_r <= 1'b0;
               bcnt    <= '0;
               if ((start_press && hold_ok) || auto_ok) begin
                  st   <= ST_INICIAL;
                  fcnt <= '0;
               end else if (frame_tick_r && (fcnt != F_MAX)) begin
                  fcnt <= fcnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign tela.estado     = estado_r;
   assign tela.troca      = troca_r;
   assign tela.jogo_reset = jogo_reset_r;
   assign tela.frame_tick = frame_tick_r;

endmodule
